// File: rtl/adsr_envelope_gen_pkg.sv
// Shared definitions for the ADSR envelope generator: state codes, level width
// and the widened add/subtract helpers used by the level datapath.
package adsr_envelope_gen_pkg;

    localparam int unsigned ENV_LEVEL_W = 16;
    localparam int unsigned ENV_OUT_W   = 8;

    typedef enum logic [2:0] {
        ENV_IDLE    = 3'd0,
        ENV_ATTACK  = 3'd1,
        ENV_DECAY   = 3'd2,
        ENV_SUSTAIN = 3'd3,
        ENV_RELEASE = 3'd4
    } env_state_e;

    typedef logic [ENV_LEVEL_W-1:0] env_level_t;
    typedef logic [ENV_LEVEL_W:0]   env_wide_t;

    // Extra MSB carries the overflow (add) or borrow (subtract) of a rate step.
    function automatic env_wide_t env_add_step(input env_level_t lvl, input logic [7:0] rate);
        return env_wide_t'(lvl) + env_wide_t'(rate) + env_wide_t'(1);
    endfunction

    function automatic env_wide_t env_sub_step(input env_level_t lvl, input logic [7:0] rate);
        return env_wide_t'(lvl) - env_wide_t'(rate) - env_wide_t'(1);
    endfunction

endpackage

// File: rtl/adsr_envelope_gen_prescaler.sv
// Free-running envelope tick prescaler: one tick every 2**PRESCALE_BITS enabled clocks.
module adsr_envelope_gen_prescaler #(
    parameter int unsigned PRESCALE_BITS = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable_i,
    output logic tick_o
);

    logic [PRESCALE_BITS-1:0] cnt_q;
    logic [PRESCALE_BITS-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (enable_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = enable_i & (&cnt_q);

endmodule

// File: rtl/adsr_envelope_gen.sv
// Gate-driven ADSR envelope generator; env_out is the top byte of a 16-bit level
// that steps once per prescaler tick, while gate edges act immediately.
module adsr_envelope_gen
    import adsr_envelope_gen_pkg::*;
#(
    parameter int unsigned PRESCALE_BITS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       gate,
    input  logic [7:0] attack_rate,
    input  logic [7:0] decay_rate,
    input  logic [7:0] sustain_level,
    input  logic [7:0] release_rate,
    output logic [7:0] env_out,
    output logic [2:0] env_state,
    output logic       env_active
);

    env_state_e state_q, state_d;
    env_level_t level_q, level_d;
    logic       gate_q, gate_d;

    logic       tick;
    logic       rise, fall;
    env_level_t sustain_target;
    env_wide_t  attack_sum, decay_diff, release_diff;

    adsr_envelope_gen_prescaler #(
        .PRESCALE_BITS (PRESCALE_BITS)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable_i (enable),
        .tick_o   (tick)
    );

    assign rise           = gate & ~gate_q;
    assign fall           = ~gate & gate_q;
    assign sustain_target = {sustain_level, 8'h00};
    assign attack_sum     = env_add_step(level_q, attack_rate);
    assign decay_diff     = env_sub_step(level_q, decay_rate);
    assign release_diff   = env_sub_step(level_q, release_rate);

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        gate_d  = gate_q;

        if (enable) begin
            gate_d = gate;
            if (rise) begin
                state_d = ENV_ATTACK;
            end else if (fall) begin
                if (state_q == ENV_ATTACK || state_q == ENV_DECAY || state_q == ENV_SUSTAIN) begin
                    state_d = ENV_RELEASE;
                end
            end else begin
                // Illegal codes recover without a tick; legal states step on tick only.
                case (state_q)
                    ENV_IDLE: begin
                        if (tick) begin
                            level_d = '0;
                        end
                    end
                    ENV_ATTACK: begin
                        if (tick) begin
                            if (attack_sum[ENV_LEVEL_W] || (&attack_sum[ENV_LEVEL_W-1:0])) begin
                                level_d = '1;
                                state_d = ENV_DECAY;
                            end else begin
                                level_d = attack_sum[ENV_LEVEL_W-1:0];
                            end
                        end
                    end
                    ENV_DECAY: begin
                        if (tick) begin
                            if (decay_diff[ENV_LEVEL_W] ||
                                (decay_diff[ENV_LEVEL_W-1:0] <= sustain_target)) begin
                                level_d = sustain_target;
                                state_d = ENV_SUSTAIN;
                            end else begin
                                level_d = decay_diff[ENV_LEVEL_W-1:0];
                            end
                        end
                    end
                    ENV_SUSTAIN: begin
                        if (tick) begin
                            level_d = sustain_target;
                        end
                    end
                    ENV_RELEASE: begin
                        if (tick) begin
                            if (release_diff[ENV_LEVEL_W] ||
                                (release_diff[ENV_LEVEL_W-1:0] == '0)) begin
                                level_d = '0;
                                state_d = ENV_IDLE;
                            end else begin
                                level_d = release_diff[ENV_LEVEL_W-1:0];
                            end
                        end
                    end
                    default: begin
                        state_d = ENV_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ENV_IDLE;
            level_q <= '0;
            gate_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            gate_q  <= gate_d;
        end
    end

    assign env_out    = level_q[ENV_LEVEL_W-1 -: ENV_OUT_W];
    assign env_state  = state_q;
    assign env_active = (state_q != ENV_IDLE);

endmodule

// File: tb/tb_adsr_envelope_gen.sv
// Scoreboard bench for adsr_envelope_gen with PRESCALE_BITS = 2 (tick every 4 enabled cycles):
// directed test-plan scenarios followed by randomized gate/enable/rate/reset traffic.
module tb_adsr_envelope_gen;

    localparam int ST_IDLE    = 0;
    localparam int ST_ATTACK  = 1;
    localparam int ST_DECAY   = 2;
    localparam int ST_SUSTAIN = 3;
    localparam int ST_RELEASE = 4;
    localparam int TICK_DIV   = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       gate;
    logic [7:0] attack_rate;
    logic [7:0] decay_rate;
    logic [7:0] sustain_level;
    logic [7:0] release_rate;
    logic [7:0] env_out;
    logic [2:0] env_state;
    logic       env_active;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [11:0] exp_q[$];

    // Reference model state
    int m_level = 0;
    int m_state = ST_IDLE;
    int m_phase = 0;
    int m_gate_prev = 0;

    always #5 clk = ~clk;

    adsr_envelope_gen #(
        .PRESCALE_BITS (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .gate          (gate),
        .attack_rate   (attack_rate),
        .decay_rate    (decay_rate),
        .sustain_level (sustain_level),
        .release_rate  (release_rate),
        .env_out       (env_out),
        .env_state     (env_state),
        .env_active    (env_active)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Envelope behaviour for one clock edge, from the rules in plain integer arithmetic.
    task automatic model_step();
        int  tgt;
        int  nl;
        bit  tick;
        bit  rise;
        bit  fall;
        if (!rst_n) begin
            m_level = 0; m_state = ST_IDLE; m_phase = 0; m_gate_prev = 0;
        end else if (enable) begin
            tick = (m_phase == TICK_DIV - 1);
            m_phase = (m_phase + 1) % TICK_DIV;
            rise = (gate == 1'b1) && (m_gate_prev == 0);
            fall = (gate == 1'b0) && (m_gate_prev == 1);
            m_gate_prev = int'(gate);
            tgt = int'(sustain_level) * 256;
            if (rise) begin
                m_state = ST_ATTACK;
            end else if (fall) begin
                if (m_state == ST_ATTACK || m_state == ST_DECAY || m_state == ST_SUSTAIN)
                    m_state = ST_RELEASE;
            end else if (tick) begin
                case (m_state)
                    ST_ATTACK: begin
                        m_level = m_level + int'(attack_rate) + 1;
                        if (m_level >= 65535) begin
                            m_level = 65535;
                            m_state = ST_DECAY;
                        end
                    end
                    ST_DECAY: begin
                        nl = m_level - (int'(decay_rate) + 1);
                        if (nl <= tgt) begin
                            m_level = tgt;
                            m_state = ST_SUSTAIN;
                        end else begin
                            m_level = nl;
                        end
                    end
                    ST_SUSTAIN: m_level = tgt;
                    ST_RELEASE: begin
                        nl = m_level - (int'(release_rate) + 1);
                        if (nl <= 0) begin
                            m_level = 0;
                            m_state = ST_IDLE;
                        end else begin
                            m_level = nl;
                        end
                    end
                    default: m_level = 0;
                endcase
            end
        end
    endtask

    // Drive one cycle: inputs are already set at this negedge; predict, then advance.
    task automatic step();
        logic [7:0] e_out;
        logic [2:0] e_st;
        model_step();
        e_out = 8'(m_level / 256);
        e_st  = 3'(m_state);
        exp_q.push_back({e_out, e_st, (m_state != ST_IDLE)});
        @(negedge clk);
    endtask

    task automatic run_until_state(input int st, input int max_cycles, output int n);
        n = 0;
        while (int'(env_state) != st && n < max_cycles) begin
            step();
            n++;
        end
    endtask

    // Monitor: every edge the DUT presents new outputs; compare against the oldest prediction.
    initial begin
        logic [11:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({env_out, env_state, env_active} !== e) begin
                    n_bad++;
                    $display("FAIL scoreboard: got out=%02h st=%0d act=%0b, expected out=%02h st=%0d act=%0b (t=%0t)",
                             env_out, env_state, env_active, e[11:4], e[3:1], e[0], $time);
                end
            end
        end
    end

    initial begin
        int n;
        int k;
        int prev;
        int snap_out;
        int snap_st;

        rst_n = 1'b0; enable = 1'b1; gate = 1'b1;
        attack_rate = 8'hFF; decay_rate = 8'hFF; sustain_level = 8'h80; release_rate = 8'h3F;
        @(negedge clk);
        repeat (3) step();
        check("reset_env_out", int'(env_out), 0);
        check("reset_env_state", int'(env_state), ST_IDLE);
        check("reset_env_active", int'(env_active), 0);

        // Gate already high at reset release: rise on first cycle
        rst_n = 1'b1;
        step();
        check("rise_after_reset", int'(env_state), ST_ATTACK);

        run_until_state(ST_DECAY, 1100, n);
        check("attack_done_state", int'(env_state), ST_DECAY);
        check("attack_cycles", n, 1023);
        check("attack_peak", int'(env_out), 8'hFF);

        run_until_state(ST_SUSTAIN, 600, n);
        check("decay_done_state", int'(env_state), ST_SUSTAIN);
        check("decay_cycles", n, 512);
        check("decay_clamp", int'(env_out), 8'h80);

        gate = 1'b0;
        step();
        check("fall_to_release", int'(env_state), ST_RELEASE);
        check("release_start_level", int'(env_out), 8'h80);
        run_until_state(ST_IDLE, 2100, n);
        check("release_done_state", int'(env_state), ST_IDLE);
        check("release_cycles", n, 2047);
        check("release_env_out", int'(env_out), 0);
        check("release_inactive", int'(env_active), 0);

        // Retrigger during release at env_out = 0x40
        gate = 1'b1;
        step();
        run_until_state(ST_SUSTAIN, 2000, n);
        check("retrig_setup_sustain", int'(env_state), ST_SUSTAIN);
        gate = 1'b0;
        step();
        k = 0;
        while (env_out != 8'h40 && k < 3000) begin
            step();
            k++;
        end
        check("retrig_reach_40", int'(env_out), 8'h40);
        gate = 1'b1;
        step();
        check("retrig_state", int'(env_state), ST_ATTACK);
        check("retrig_level_kept", int'(env_out), 8'h40);
        prev = int'(env_out);
        for (int i = 0; i < 40; i++) begin
            step();
            check("retrig_monotonic", int'(int'(env_out) >= prev), 1);
            prev = int'(env_out);
        end
        check("retrig_progress", int'(env_out > 8'h40), 1);

        // Freeze mid-attack
        step(); step();
        snap_out = m_level / 256;
        snap_st  = m_state;
        enable = 1'b0;
        gate = 1'b0;
        repeat (100) step();
        check("freeze_env_out", int'(env_out), snap_out);
        check("freeze_env_state", int'(env_state), snap_st);
        gate = 1'b1;
        enable = 1'b1;
        repeat (30) step();

        // One-cycle reset mid-attack
        rst_n = 1'b0;
        step();
        check("midreset_env_out", int'(env_out), 0);
        check("midreset_env_state", int'(env_state), ST_IDLE);
        rst_n = 1'b1;
        repeat (20) step();

        // Randomized traffic
        for (int i = 0; i < 6000; i++) begin
            if (i % 400 == 0) begin
                attack_rate  = 8'($urandom_range(128, 255));
                decay_rate   = 8'($urandom_range(64, 255));
                release_rate = 8'($urandom_range(64, 255));
                case ($urandom_range(0, 3))
                    0: sustain_level = 8'h00;
                    1: sustain_level = 8'hFF;
                    default: sustain_level = 8'($urandom_range(0, 255));
                endcase
            end
            if ($urandom_range(0, 149) == 0) gate = ~gate;
            enable = ($urandom_range(0, 15) != 0);
            rst_n  = ($urandom_range(0, 2999) != 0);
            step();
        end
        rst_n = 1'b1;
        enable = 1'b1;
        step();

        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/adsr_envelope_gen.md
Name: adsr_envelope_gen

Overview:
- Gate-driven ADSR envelope generator producing an 8-bit amplitude envelope.
- Sits between the gate logic and the volume multiplier. Its env_out scales the mixed waveform ahead of the delta-sigma DAC, and its MSB drives the ENV_OUT visual pin.
- Rates and sustain level come straight from I2C registers.
- A rate prescaler slows envelope stepping to audio-envelope time scales.

Parameters:
- PRESCALE_BITS, 8, width of the tick prescaler; one envelope tick every 2**PRESCALE_BITS enabled clocks.

Ports:
- clk  input  1  system clock (50 MHz).
- rst_n  input  1  synchronous active-low reset.
- enable  input  1  high = run; low = freeze prescaler, level and state.
- gate  input  1  note gate (hardware pin OR software gate), level-sensitive.
- attack_rate  input  8  attack step = attack_rate+1 per tick.
- decay_rate  input  8  decay step = decay_rate+1 per tick.
- sustain_level  input  8  sustain target, compared against level[15:8].
- release_rate  input  8  release step = release_rate+1 per tick.
- env_out  output  8  envelope value = level[15:8].
- env_state  output  3  current state encoding.
- env_active  output  1  high when env_state != IDLE.

Behaviour:
- Interface: one clock, clk. rst_n is synchronous and active-low, sampled on posedge clk only.
- Reset values:
  - level = 16'h0000, so env_out = 0.
  - env_state = IDLE (0), env_active = 0.
  - prescaler = 0, gate_q = 0.
- All outputs are direct decodes of registers; there is no extra output latency.
- Prescaler:
  - Increments each enabled cycle and wraps from all-ones to 0.
  - tick = enable AND (prescaler == all-ones).
- Edge detect:
  - gate_q <= gate each enabled cycle.
  - rise = gate & ~gate_q; fall = ~gate & gate_q.
  - Edges act on the cycle they are detected; they do not wait for a tick.
- State encoding: IDLE 0, ATTACK 1, DECAY 2, SUSTAIN 3, RELEASE 4. Codes 5-7 are illegal and recover to IDLE with level unchanged.
- Transitions, by priority:
  1. rise, any state -> ATTACK. Level is kept (legato retrigger; no drop to 0).
  2. fall in ATTACK, DECAY or SUSTAIN -> RELEASE.
  3. tick performs the per-state action below.
- On a cycle with an edge, no tick action is taken and the level is unchanged.
- Per-state tick action (all arithmetic on the 16-bit level, 9-bit step zero-extended):
  - ATTACK: level += attack_rate+1, saturating at 16'hFFFF. Reaching 16'hFFFF on this tick -> DECAY.
  - DECAY: target = {sustain_level, 8'h00}. If level - step <= target (including underflow), level = target and go to SUSTAIN; else level -= step.
  - SUSTAIN: level = {sustain_level, 8'h00} every tick, so live sustain edits take effect at the next tick.
  - RELEASE: level -= release_rate+1, floored at 0. Reaching 0 -> IDLE.
  - IDLE: level held at 0.
- Boundary cases:
  - sustain_level = 0: DECAY ends at level 0 and stays in SUSTAIN with env_active = 1 until gate falls.
  - sustain_level = 8'hFF: target 16'hFF00; DECAY completes in one tick for decay_rate = 8'hFF.
  - Gate already high when reset deasserts: gate_q = 0, so a rise is detected on the first enabled cycle -> ATTACK.
  - fall while in IDLE or RELEASE: ignored.
  - enable low: every register holds, and edges are not sampled. A gate change made while disabled is seen at re-enable.
  - Reset mid-operation: all registers return to reset values on the next posedge.

Decomposition:
- Shared header adsr_defs.vh holds the state localparams (ENV_IDLE..ENV_RELEASE) and ENV_LEVEL_W = 16.
- One natural sub-module, env_prescaler: counter plus tick output, parameterised by PRESCALE_BITS.
- State machine and level datapath stay in the top block.

Test Plan (bench uses PRESCALE_BITS = 2, i.e. a tick every 4 cycles):
- Reset with gate = 1, enable = 1, then deassert rst_n:
  - While rst_n is low: env_out = 0, env_state = 0, env_active = 0.
  - On the first post-reset cycle: rise detected -> env_state = 1.
- Attack, attack_rate = 8'hFF (step 256) from level 0: after 256 ticks, level = 16'hFFFF, env_out = 8'hFF, env_state = 2.
- Decay, decay_rate = 8'hFF, sustain_level = 8'h80 from 16'hFFFF: at tick 128, level clamps to 16'h8000, env_out = 8'h80, env_state = 3, with no undershoot below 8'h80 at any point.
- Release: drop gate in SUSTAIN at 16'h8000 with release_rate = 8'h3F (step 64).
  - env_state = 4 on the next cycle.
  - After 512 ticks, level = 0, env_state = 0, env_active = 0.
- Retrigger: raise gate during RELEASE at env_out = 8'h40.
  - Next cycle: env_state = 1 and env_out still 8'h40.
  - Level then rises monotonically.
- Freeze and reset mid-attack:
  - enable = 0 for 100 cycles mid-ATTACK: env_out and env_state are unchanged.
  - Re-enable: stepping resumes at the same prescaler phase.
  - Assert rst_n = 0 for one cycle mid-ATTACK: env_out = 0 and env_state = 0 after that edge.
